// File: rtl/mem_access_lsu_if.sv
// Request/response data bus between the memory-access stage (master) and memory (slave).
interface mem_access_lsu_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              bus_req_valid;
  logic              bus_req_ready;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [DATA_W-1:0] bus_wdata;
  logic [7:0]        bus_wmask;
  logic              bus_resp_valid;
  logic [DATA_W-1:0] bus_rdata;

  modport master (
    output bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wmask,
    input  bus_req_ready, bus_resp_valid, bus_rdata
  );

  modport slave (
    input  bus_req_valid, bus_addr, bus_we, bus_wdata, bus_wmask,
    output bus_req_ready, bus_resp_valid, bus_rdata
  );
endinterface

// File: rtl/mem_access_lsu.sv
// Memory-access stage: one instruction at a time, issues loads/stores on the data bus and
// hands aligned load data to write-back. MEM_ACCESS_LSU_MISALIGN_TRAP_EN adds misalign trapping.
module mem_access_lsu #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [63:0]       ex_alu_out,
  input  logic [DATA_W-1:0] ex_store_data,
  input  logic              ex_mem_rd,
  input  logic              ex_mem_wr,
  input  logic [2:0]        ex_funct3,
  input  logic [4:0]        ex_rd,
  input  logic              ex_MemtoReg,
  input  logic              ex_RegWr,
  mem_access_lsu_if.master  bus,
  output logic              wb_valid,
  input  logic              wb_ready,
  output logic [63:0]       alu_out,
  output logic [DATA_W-1:0] mem_data,
  output logic [4:0]        rd,
  output logic              MemtoReg,
  output logic              RegWr
`ifdef MEM_ACCESS_LSU_MISALIGN_TRAP_EN
  ,
  output logic              misalign
`endif
);

  typedef enum logic [1:0] {IDLE, REQ, RESP, HOLD} state_t;
  state_t state;

  logic [2:0]  off_q;
  logic [1:0]  size_q;
  logic        uns_q;
  logic        load_q;

  logic [2:0]  acc_off;
  logic [7:0]  acc_base;
  logic [7:0]  acc_mask;
  logic [63:0] acc_wdata;
  logic        is_mem;
  logic        trap;
  logic        go_bus;

  logic [63:0] ld_shift;
  logic [63:0] ld_data;

  assign ex_ready = (state == IDLE);

  always_comb begin
    acc_off = ex_alu_out[2:0];
    case (ex_funct3[1:0])
      2'd0:    acc_base = 8'h01;
      2'd1:    acc_base = 8'h03;
      2'd2:    acc_base = 8'h0F;
      default: acc_base = 8'hFF;
    endcase
    acc_mask  = acc_base << acc_off;
    acc_wdata = ex_store_data << {acc_off, 3'b000};
    is_mem    = ex_mem_rd || ex_mem_wr;
    trap      = 1'b0;
`ifdef MEM_ACCESS_LSU_MISALIGN_TRAP_EN
    case (ex_funct3[1:0])
      2'd0:    trap = 1'b0;
      2'd1:    trap = is_mem && acc_off[0];
      2'd2:    trap = is_mem && (|acc_off[1:0]);
      default: trap = is_mem && (|acc_off);
    endcase
`endif
    go_bus = is_mem && !trap;
  end

  // Load data: shift the addressed byte down to lane 0, then truncate and extend by size.
  always_comb begin
    ld_shift = bus.bus_rdata >> {off_q, 3'b000};
    case (size_q)
      2'd0:    ld_data = uns_q ? {56'd0, ld_shift[7:0]}  : {{56{ld_shift[7]}},  ld_shift[7:0]};
      2'd1:    ld_data = uns_q ? {48'd0, ld_shift[15:0]} : {{48{ld_shift[15]}}, ld_shift[15:0]};
      2'd2:    ld_data = uns_q ? {32'd0, ld_shift[31:0]} : {{32{ld_shift[31]}}, ld_shift[31:0]};
      default: ld_data = ld_shift;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state             <= IDLE;
      bus.bus_req_valid <= 1'b0;
      bus.bus_addr      <= '0;
      bus.bus_we        <= 1'b0;
      bus.bus_wdata     <= '0;
      bus.bus_wmask     <= '0;
      wb_valid          <= 1'b0;
      alu_out           <= '0;
      mem_data          <= '0;
      rd                <= '0;
      MemtoReg          <= 1'b0;
      RegWr             <= 1'b0;
      off_q             <= '0;
      size_q            <= '0;
      uns_q             <= 1'b0;
      load_q            <= 1'b0;
`ifdef MEM_ACCESS_LSU_MISALIGN_TRAP_EN
      misalign          <= 1'b0;
`endif
    end else begin
      case (state)
        IDLE: begin
          if (ex_valid) begin
            alu_out  <= ex_alu_out;
            rd       <= ex_rd;
            MemtoReg <= ex_MemtoReg;
            RegWr    <= ex_RegWr && !trap;
            off_q    <= acc_off;
            size_q   <= ex_funct3[1:0];
            uns_q    <= ex_funct3[2];
            load_q   <= ex_mem_rd;
            if (go_bus) begin
              state             <= REQ;
              bus.bus_req_valid <= 1'b1;
              bus.bus_addr      <= {ex_alu_out[ADDR_W-1:3], 3'b000};
              bus.bus_we        <= !ex_mem_rd;
              bus.bus_wmask     <= acc_mask;
              bus.bus_wdata     <= ex_mem_rd ? '0 : acc_wdata;
            end else begin
              state    <= HOLD;
              wb_valid <= 1'b1;
              mem_data <= '0;
`ifdef MEM_ACCESS_LSU_MISALIGN_TRAP_EN
              misalign <= trap;
`endif
            end
          end
        end
        REQ: begin
          if (bus.bus_req_ready) begin
            state             <= RESP;
            bus.bus_req_valid <= 1'b0;
          end
        end
        RESP: begin
          if (bus.bus_resp_valid) begin
            state    <= HOLD;
            wb_valid <= 1'b1;
            mem_data <= load_q ? ld_data : '0;
          end
        end
        HOLD: begin
          if (wb_ready) begin
            state    <= IDLE;
            wb_valid <= 1'b0;
`ifdef MEM_ACCESS_LSU_MISALIGN_TRAP_EN
            misalign <= 1'b0;
`endif
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_lsu.sv
// Randomized self-checking bench for mem_access_lsu against a byte-level reference model.
module tb_mem_access_lsu;

  logic        clk;
  logic        rst_n;
  logic        ex_valid;
  logic        ex_ready;
  logic [63:0] ex_alu_out;
  logic [63:0] ex_store_data;
  logic        ex_mem_rd;
  logic        ex_mem_wr;
  logic [2:0]  ex_funct3;
  logic [4:0]  ex_rd;
  logic        ex_MemtoReg;
  logic        ex_RegWr;
  logic        wb_valid;
  logic        wb_ready;
  logic [63:0] alu_out;
  logic [63:0] mem_data;
  logic [4:0]  rd;
  logic        MemtoReg;
  logic        RegWr;

  int unsigned errors;
  int unsigned checks;

  mem_access_lsu_if #(.ADDR_W(64), .DATA_W(64)) bus_if ();

  mem_access_lsu #(.ADDR_W(64), .DATA_W(64)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .ex_valid      (ex_valid),
    .ex_ready      (ex_ready),
    .ex_alu_out    (ex_alu_out),
    .ex_store_data (ex_store_data),
    .ex_mem_rd     (ex_mem_rd),
    .ex_mem_wr     (ex_mem_wr),
    .ex_funct3     (ex_funct3),
    .ex_rd         (ex_rd),
    .ex_MemtoReg   (ex_MemtoReg),
    .ex_RegWr      (ex_RegWr),
    .bus           (bus_if.master),
    .wb_valid      (wb_valid),
    .wb_ready      (wb_ready),
    .alu_out       (alu_out),
    .mem_data      (mem_data),
    .rd            (rd),
    .MemtoReg      (MemtoReg),
    .RegWr         (RegWr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic int unsigned nbytes(input logic [2:0] f3);
    return 1 << f3[1:0];
  endfunction

  function automatic logic [7:0] model_mask(input logic [63:0] a, input logic [2:0] f3);
    logic [7:0] m = '0;
    for (int i = 0; i < int'(nbytes(f3)); i++)
      if (int'(a[2:0]) + i < 8) m[int'(a[2:0]) + i] = 1'b1;
    return m;
  endfunction

  function automatic logic [63:0] model_wdata(input logic [63:0] a, input logic [63:0] sd);
    logic [63:0] w = '0;
    for (int i = 0; i < 8; i++)
      if (int'(a[2:0]) + i < 8) w[8*(int'(a[2:0]) + i) +: 8] = sd[8*i +: 8];
    return w;
  endfunction

  function automatic logic [63:0] model_load(input logic [63:0] rdata, input logic [63:0] a,
                                             input logic [2:0] f3);
    logic [63:0] v = '0;
    int n = int'(nbytes(f3));
    for (int i = 0; i < n; i++)
      if (int'(a[2:0]) + i < 8) v[8*i +: 8] = rdata[8*(int'(a[2:0]) + i) +: 8];
    if (!f3[2] && n < 8 && v[8*n-1])
      for (int b = 8*n; b < 64; b++) v[b] = 1'b1;
    return v;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic run_txn(input logic [63:0] a, input logic [63:0] sd, input logic rdq,
                         input logic wrq, input logic [2:0] f3, input logic [4:0] r,
                         input logic m2r, input logic rw, input logic [63:0] rdata,
                         input int unsigned req_wait, input int unsigned resp_wait,
                         input int unsigned wb_wait, output logic [63:0] got_mem);
    logic        is_mem = rdq || wrq;
    logic [63:0] exp_addr = {a[63:3], 3'b000};
    logic [7:0]  exp_mask = model_mask(a, f3);
    logic [63:0] exp_mem  = rdq ? model_load(rdata, a, f3) : 64'd0;
    check("ex_ready_idle", ex_ready, 1'b1);
    ex_valid = 1'b1; ex_alu_out = a; ex_store_data = sd; ex_mem_rd = rdq; ex_mem_wr = wrq;
    ex_funct3 = f3; ex_rd = r; ex_MemtoReg = m2r; ex_RegWr = rw;
    tick();
    ex_valid = 1'b0;
    ex_alu_out = {$urandom, $urandom}; ex_rd = 5'($urandom);
    if (!is_mem) begin
      check("alu_no_req", bus_if.bus_req_valid, 1'b0);
    end else begin
      check("wb_valid_req", wb_valid, 1'b0);
      check("req_valid", bus_if.bus_req_valid, 1'b1);
      check("req_addr", bus_if.bus_addr, exp_addr);
      check("req_we", bus_if.bus_we, wrq && !rdq);
      check("req_mask", bus_if.bus_wmask, exp_mask);
      if (!rdq) check("req_wdata", bus_if.bus_wdata, model_wdata(a, sd));
      for (int unsigned i = 0; i < req_wait; i++) begin
        bus_if.bus_req_ready = 1'b0;
        tick();
        check("req_hold_valid", bus_if.bus_req_valid, 1'b1);
        check("req_hold_addr", bus_if.bus_addr, exp_addr);
        check("req_hold_mask", bus_if.bus_wmask, exp_mask);
        if (!rdq) check("req_hold_wdata", bus_if.bus_wdata, model_wdata(a, sd));
      end
      bus_if.bus_req_ready = 1'b1;
      tick();
      bus_if.bus_req_ready = 1'b0;
      check("req_dropped", bus_if.bus_req_valid, 1'b0);
      for (int unsigned i = 0; i < resp_wait; i++) begin
        tick();
        check("wb_valid_resp_wait", wb_valid, 1'b0);
      end
      bus_if.bus_resp_valid = 1'b1;
      bus_if.bus_rdata = rdata;
      tick();
      bus_if.bus_resp_valid = 1'b0;
      bus_if.bus_rdata = {$urandom, $urandom};
    end
    check("wb_valid", wb_valid, 1'b1);
    check("wb_alu_out", alu_out, a);
    check("wb_mem_data", mem_data, exp_mem);
    check("wb_rd", rd, r);
    check("wb_MemtoReg", MemtoReg, m2r);
    check("wb_RegWr", RegWr, rw);
    check("ex_ready_busy", ex_ready, 1'b0);
    got_mem = mem_data;
    for (int unsigned i = 0; i < wb_wait; i++) begin
      tick();
      check("wb_hold_valid", wb_valid, 1'b1);
      check("wb_hold_data", mem_data, exp_mem);
      check("wb_hold_alu", alu_out, a);
      check("ex_ready_hold", ex_ready, 1'b0);
    end
    wb_ready = 1'b1;
    tick();
    wb_ready = 1'b0;
    check("wb_release", wb_valid, 1'b0);
    check("ex_ready_back", ex_ready, 1'b1);
  endtask

  initial begin
    logic [63:0] got;
    logic [2:0]  f3;
    int unsigned kind;
    errors = 0; checks = 0;
    rst_n = 1'b0; ex_valid = 1'b0; ex_alu_out = '0; ex_store_data = '0; ex_mem_rd = 1'b0;
    ex_mem_wr = 1'b0; ex_funct3 = '0; ex_rd = '0; ex_MemtoReg = 1'b0; ex_RegWr = 1'b0;
    wb_ready = 1'b0;
    bus_if.bus_req_ready = 1'b0; bus_if.bus_resp_valid = 1'b0; bus_if.bus_rdata = '0;
    tick(); tick();
    check("rst_ex_ready", ex_ready, 1'b1);
    check("rst_wb_valid", wb_valid, 1'b0);
    check("rst_req_valid", bus_if.bus_req_valid, 1'b0);
    check("rst_alu_out", alu_out, 64'd0);
    check("rst_mem_data", mem_data, 64'd0);
    check("rst_addr", bus_if.bus_addr, 64'd0);
    check("rst_mask", bus_if.bus_wmask, 8'd0);
    rst_n = 1'b1;
    tick();

    run_txn(64'h1234, 64'd0, 1'b0, 1'b0, 3'd0, 5'd5, 1'b0, 1'b1, 64'd0, 0, 0, 0, got);
    run_txn(64'h1003, 64'd0, 1'b1, 1'b0, 3'd0, 5'd7, 1'b1, 1'b1,
            64'h0000_0000_8000_0000, 0, 0, 0, got);
    check("lb_const", got, 64'hFFFF_FFFF_FFFF_FF80);
    run_txn(64'h2006, 64'd0, 1'b1, 1'b0, 3'd5, 5'd8, 1'b1, 1'b1,
            64'hBEEF_0000_0000_0000, 0, 0, 0, got);
    check("lhu_const", got, 64'h0000_0000_0000_BEEF);
    run_txn(64'h3004, 64'hDEADBEEF, 1'b0, 1'b1, 3'd2, 5'd0, 1'b0, 1'b0,
            64'hFFFF_FFFF_FFFF_FFFF, 3, 1, 0, got);
    check("sw_mem_zero", got, 64'd0);
    run_txn(64'h4000, 64'd0, 1'b1, 1'b0, 3'd3, 5'd9, 1'b1, 1'b1,
            64'h0123_4567_89AB_CDEF, 0, 0, 4, got);

    // Reset while waiting for the response, then a stray response in IDLE.
    ex_valid = 1'b1; ex_alu_out = 64'h5008; ex_mem_rd = 1'b1; ex_mem_wr = 1'b0;
    ex_funct3 = 3'd3; ex_rd = 5'd3; ex_MemtoReg = 1'b1; ex_RegWr = 1'b1;
    tick();
    ex_valid = 1'b0;
    bus_if.bus_req_ready = 1'b1;
    tick();
    bus_if.bus_req_ready = 1'b0;
    rst_n = 1'b0;
    #1;
    check("arst_req_valid", bus_if.bus_req_valid, 1'b0);
    check("arst_wb_valid", wb_valid, 1'b0);
    check("arst_alu_out", alu_out, 64'd0);
    check("arst_rd", rd, 5'd0);
    check("arst_RegWr", RegWr, 1'b0);
    check("arst_MemtoReg", MemtoReg, 1'b0);
    check("arst_addr", bus_if.bus_addr, 64'd0);
    check("arst_ex_ready", ex_ready, 1'b1);
    #1;
    rst_n = 1'b1;
    tick();
    bus_if.bus_resp_valid = 1'b1;
    bus_if.bus_rdata = 64'hFFFF_FFFF_FFFF_FFFF;
    tick();
    bus_if.bus_resp_valid = 1'b0;
    check("stray_resp_wb", wb_valid, 1'b0);
    tick();
    check("stray_resp_wb2", wb_valid, 1'b0);
    check("stray_resp_mem", mem_data, 64'd0);

    for (int t = 0; t < 60; t++) begin
      kind = $urandom_range(0, 3);
      f3 = 3'($urandom);
      if (kind == 2) f3[2] = 1'b0;
      run_txn({$urandom, $urandom}, {$urandom, $urandom},
              kind == 1 || kind == 3, kind == 2 || kind == 3, f3, 5'($urandom),
              1'($urandom), 1'($urandom), {$urandom, $urandom},
              $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3), got);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mem_access_lsu.md
Name: mem_access_lsu

Overview:
- Memory-access stage that produces the load data consumed by write-back.
- Takes one instruction at a time from execute over a valid/ready handshake.
- Issues the load or store on a request/response data bus, aligns and extends load data, then presents alu_out, mem_data, rd and the control bits to write-back.
- Non-memory instructions pass through without a bus transaction.

Parameters:
- ADDR_W, 64, bus address width.
- DATA_W, 64, bus and register data width; fixed at 64, so the byte strobe is 8 bits.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- ex_valid  in  1  execute has an instruction
- ex_ready  out  1  stage can accept an instruction
- ex_alu_out  in  64  ALU result; this is the address for loads and stores
- ex_store_data  in  64  store source (rs2)
- ex_mem_rd  in  1  instruction is a load
- ex_mem_wr  in  1  instruction is a store
- ex_funct3  in  3  [1:0] size (0=B, 1=H, 2=W, 3=D); [2] unsigned load
- ex_rd  in  5  destination register
- ex_MemtoReg  in  1  write-back selects mem_data
- ex_RegWr  in  1  register write enable
- bus_req_valid  out  1  bus request
- bus_req_ready  in  1  bus accepts the request
- bus_addr  out  ADDR_W  8-byte-aligned address
- bus_we  out  1  1=store
- bus_wdata  out  64  store data, lane-shifted
- bus_wmask  out  8  byte strobe
- bus_resp_valid  in  1  response or store acknowledge
- bus_rdata  in  64  read data
- wb_valid  out  1  write-back payload valid
- wb_ready  in  1  write-back consumes the payload
- alu_out  out  64  registered ALU result
- mem_data  out  64  aligned, extended load data
- rd  out  5  registered destination
- MemtoReg  out  1  registered select
- RegWr  out  1  registered write enable

Behaviour:
- FSM states: IDLE, REQ, RESP, HOLD.
- Reset (any time, asynchronous): state=IDLE. Outputs: bus_req_valid=0, wb_valid=0, alu_out=0, mem_data=0, rd=0, MemtoReg=0, RegWr=0, bus_addr/wdata/wmask=0. ex_ready=1 in IDLE. A bus transaction in flight is abandoned, and any late bus_resp_valid seen in IDLE is ignored.
- ex_ready is 1 only in IDLE.
- Accept occurs on ex_valid&&ex_ready. On accept, all ex_* fields are captured.
  - Neither mem_rd nor mem_wr: go to HOLD. wb_valid=1 on the next cycle (latency 1); mem_data=0.
  - Load or store: go to REQ. bus_req_valid=1 on the next cycle.
  - mem_rd and mem_wr both set: treated as a load.
- Request formation:
  - bus_addr = {alu_out[ADDR_W-1:3], 3'b000}; off = alu_out[2:0].
  - bus_wmask = (size mask: 0x01 / 0x03 / 0x0F / 0xFF) << off, truncated to 8 bits.
  - bus_wdata = store_data << (off*8).
  - For loads, bus_wmask carries the same read mask and bus_we=0.
- REQ: bus_req_valid and the request fields are held stable until bus_req_ready. On the handshake, go to RESP and drop bus_req_valid.
- RESP: wait for bus_resp_valid, with no timeout.
  - Load: mem_data = bus_rdata >> (off*8), then truncated to size. Sign-extended when funct3[2]=0, zero-extended when funct3[2]=1.
  - Store: mem_data=0.
  - Then go to HOLD with wb_valid=1 on the next cycle.
  - bus_resp_valid in the same cycle as the REQ handshake is not allowed by the bus protocol and is not examined.
- HOLD: wb_valid=1. The payload is stable until wb_ready. On wb_ready, go to IDLE with wb_valid=0 on the next cycle. There is no same-cycle re-accept, so peak throughput is one instruction per 2 cycles for non-memory instructions.
- Minimum load latency with a zero-wait bus: accept at cycle 0, REQ at 1, RESP at 2 (resp in cycle 2), wb_valid at 3.
- Misaligned accesses (off not a multiple of the access size) are issued as computed; the mask is truncated inside the 8-byte lane.

Optional Feature:
- Macro: MEM_ACCESS_LSU_MISALIGN_TRAP_EN.
- Defined:
  - A misaligned load or store skips the bus and goes straight to HOLD.
  - RegWr is forced to 0.
  - Extra output misalign (1 bit) is 1 while wb_valid, and 0 after reset.
- Undefined: the misalign port is absent and misaligned accesses are issued as described in Behaviour.

Test Plan:
- ALU op alu_out=0x1234, rd=5, RegWr=1, wb_ready=1 -> wb_valid on the cycle after accept with alu_out=0x1234, rd=5, RegWr=1, MemtoReg=0; no bus_req_valid.
- LB at addr 0x1003 (funct3=0), bus_rdata=0x00000000_80000000 -> bus_addr=0x1000, wmask=0x08, mem_data=0xFFFFFFFF_FFFFFF80; wb_valid at cycle 3 with a zero-wait bus.
- LHU at addr 0x2006 (funct3=5), bus_rdata=0xBEEF_0000_0000_0000 -> mem_data=0x000000000000BEEF.
- SW at addr 0x3004, store_data=0xDEADBEEF, bus_req_ready held low for 3 cycles -> request fields stable throughout with wmask=0xF0 and wdata=0xDEADBEEF_00000000; wb_valid follows the resp.
- wb_ready low for 4 cycles after a load -> payload stable and ex_ready=0 throughout; ex_ready=1 the cycle after wb_ready.
- rst_n asserted while in RESP -> all outputs 0 immediately and state IDLE; a subsequent stray bus_resp_valid produces no wb_valid.
